transmit_parity_tx: RTL and testbench

- Transmit end of the 10-bit parity-protected channel: 9 payload bits plus 1 parity bit.
- Accepts 9-bit payloads over a valid/ready handshake and buffers them in a small FIFO.
- Appends even parity: bit 9 = XOR of bits 8:0, so every 10-bit word has an even number of ones.
- Emits words on a registered 10-bit bus at a programmable pace, with a one-cycle strobe per new word. The channel receiver samples this bus and flags a word valid when bit 9 equals XOR(bits 8:0).

---
 rtl/transmit_parity_tx.sv | 109 ++++++++++
 tb/tb_transmit_parity_tx.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmit_parity_tx.sv
// transmit_parity_tx: even-parity word transmitter with FIFO buffering and paced output
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   in_data_i      9-bit payload to transmit
//   in_valid_i     in_data_i is presented
//   in_ready_o     FIFO can accept (combinational, = !full)
//   data_out_o     registered {parity, payload}; holds the last emitted word
//   tx_strobe_o    registered one-cycle pulse when data_out_o takes a new word
//   fifo_count_o   number of buffered words
//   err_inject_i   present only when PARITY_INJECT_EN is defined; arms inversion
//                  of the parity bit of the next emitted word
//
// Configuration macro: PARITY_INJECT_EN (undefined by default, parity always correct).
module transmit_parity_tx #(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [8:0]                 in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [9:0]                 data_out_o,
    output logic                       tx_strobe_o,
    output logic [$clog2(DEPTH):0]     fifo_count_o
`ifdef PARITY_INJECT_EN
    ,
    input  logic                       err_inject_i
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, PAUSE} state_t;

    state_t        state_q, state_d;
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    gap_q, gap_d;
    logic [9:0]    data_q, data_d;
    logic          strobe_q;
    logic          push, pop, flip;
    logic [8:0]    head;

    // Full blocks pushes even when a pop happens on the same edge.
    assign in_ready_o   = count_q != (AW+1)'(DEPTH);
    assign push         = in_valid_i && in_ready_o;
    assign pop          = (state_q == IDLE) && (count_q != '0);
    assign head         = mem_q[rd_ptr_q];
    assign data_out_o   = data_q;
    assign tx_strobe_o  = strobe_q;
    assign fifo_count_o = count_q;

`ifdef PARITY_INJECT_EN
    logic arm_q;

    // A request on the popping edge itself corrupts that word; the arm clears on any pop.
    assign flip = arm_q || err_inject_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arm_q <= 1'b0;
        else        arm_q <= pop ? 1'b0 : flip;
    end
`else
    assign flip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        data_d  = pop ? {^head ^ flip, head} : data_q;
        if (state_q == IDLE) begin
            if (pop && GAP != 0) begin
                state_d = PAUSE;
                gap_d   = 8'(GAP);
            end
        end else begin
            gap_d   = gap_q - 8'd1;
            state_d = (gap_q == 8'd1) ? IDLE : PAUSE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            count_q  <= '0;
            data_q   <= '0;
            strobe_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            data_q   <= data_d;
            strobe_q <= pop;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end
endmodule

// File: tb/tb_transmit_parity_tx.sv
// tb_transmit_parity_tx: scoreboard bench for transmit_parity_tx at GAP 0, 2 and 8
module tb_transmit_parity_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [9:0] dout [3];
    logic       strb [3];
    logic       rdy  [3];
    logic [2:0] cnt  [3];
`ifdef PARITY_INJECT_EN
    logic       err_inject = 1'b0;
`endif

    int         checks = 0;
    int         fails = 0;
    logic [9:0] exp_q [$];
    logic [9:0] e;

    always #5 clk = ~clk;

    transmit_parity_tx #(.DEPTH(4), .GAP(0)) u_g0 (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(rdy[0]), .data_out_o(dout[0]), .tx_strobe_o(strb[0]), .fifo_count_o(cnt[0])
`ifdef PARITY_INJECT_EN
        , .err_inject_i(err_inject)
`endif
    );

    transmit_parity_tx #(.DEPTH(4), .GAP(2)) u_g2 (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(rdy[1]), .data_out_o(dout[1]), .tx_strobe_o(strb[1]), .fifo_count_o(cnt[1])
`ifdef PARITY_INJECT_EN
        , .err_inject_i(err_inject)
`endif
    );

    transmit_parity_tx #(.DEPTH(4), .GAP(8)) u_g8 (
        .clk(clk), .rst_n(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(rdy[2]), .data_out_o(dout[2]), .tx_strobe_o(strb[2]), .fifo_count_o(cnt[2])
`ifdef PARITY_INJECT_EN
        , .err_inject_i(err_inject)
`endif
    );

    task automatic reset_dut;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset;
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout[k] !== 10'h000 || strb[k] !== 1'b0 || rdy[k] !== 1'b1 || cnt[k] !== 3'd0) begin
                fails++;
                $display("FAIL reset_state[%0d]: dout=%h strb=%b rdy=%b cnt=%0d, want 000 0 1 0",
                         k, dout[k], strb[k], rdy[k], cnt[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        reset_dut();
        @(negedge clk);
        in_data = 9'h1A5;
        in_valid = 1'b1;
        exp_q.push_back(10'h3A5);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (strb[0] !== 1'b0 || cnt[0] !== 3'd1) begin
            fails++;
            $display("FAIL single_latency: strb=%b cnt=%0d, want 0 1", strb[0], cnt[0]);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (strb[0] !== 1'b1 || dout[0] !== e) begin
            fails++;
            $display("FAIL single_emit: strb=%b dout=%h, want 1 %h", strb[0], dout[0], e);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (strb[0] !== 1'b0 || dout[0] !== 10'h3A5) begin
                fails++;
                $display("FAIL single_hold: strb=%b dout=%h, want 0 3a5", strb[0], dout[0]);
            end
        end
    endtask

    task automatic test_pacing;
        logic [8:0] w [2];
        logic [9:0] x [2];
        int idx, n, last;
        w = '{9'h003, 9'h007};
        x = '{10'h003, 10'h207};
        idx = 0;
        n = 0;
        last = -1;
        reset_dut();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (strb[1]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL pace_extra: strobe with %h, nothing expected", dout[1]);
                end else begin
                    e = exp_q.pop_front();
                    if (dout[1] !== e) begin
                        fails++;
                        $display("FAIL pace_data: got %h, want %h", dout[1], e);
                    end
                end
                checks++;
                if (n == 0 ? c != 2 : c - last != 3) begin
                    fails++;
                    $display("FAIL pace_spacing: strobe at cycle %0d, previous %0d", c, last);
                end
                last = c;
                n++;
            end
            if (idx < 2) begin
                in_valid = 1'b1;
                in_data = w[idx];
                if (rdy[1]) begin
                    exp_q.push_back(x[idx]);
                    idx++;
                end
            end else in_valid = 1'b0;
        end
        checks++;
        if (n != 2 || exp_q.size() != 0 || dout[1] !== 10'h207) begin
            fails++;
            $display("FAIL pace_total: strobes=%0d left=%0d dout=%h, want 2 0 207", n, exp_q.size(), dout[1]);
        end
    endtask

    task automatic test_backpressure;
        logic [8:0] w [6];
        logic [9:0] x [6];
        int idx, m, n, last, full_seen;
        w = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006};
        x = '{10'h201, 10'h202, 10'h003, 10'h204, 10'h005, 10'h006};
        idx = 0;
        m = 0;
        n = 0;
        last = -1;
        full_seen = 0;
        reset_dut();
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (strb[2]) begin
                m--;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: strobe with %h, nothing expected", dout[2]);
                end else begin
                    e = exp_q.pop_front();
                    if (dout[2] !== e) begin
                        fails++;
                        $display("FAIL bp_data: got %h, want %h", dout[2], e);
                    end
                end
                checks++;
                if (n == 0 ? c != 2 : c - last != 9) begin
                    fails++;
                    $display("FAIL bp_spacing: strobe at cycle %0d, previous %0d", c, last);
                end
                last = c;
                n++;
            end
            checks++;
            if (cnt[2] !== m[2:0] || rdy[2] !== (m != 4)) begin
                fails++;
                $display("FAIL bp_level: cycle %0d cnt=%0d rdy=%b, want %0d %b", c, cnt[2], rdy[2], m, m != 4);
            end
            if (!rdy[2]) full_seen = 1;
            if (idx < 6) begin
                in_valid = 1'b1;
                in_data = w[idx];
                if (rdy[2]) begin
                    exp_q.push_back(x[idx]);
                    idx++;
                    m++;
                end
            end else in_valid = 1'b0;
        end
        checks++;
        if (n != 6 || exp_q.size() != 0 || full_seen == 0) begin
            fails++;
            $display("FAIL bp_total: strobes=%0d left=%0d full_seen=%0d, want 6 0 1", n, exp_q.size(), full_seen);
        end
    endtask

    task automatic test_reset_mid;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 9'h010 + 9'(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (cnt[2] !== 3'd3) begin
            fails++;
            $display("FAIL rmid_pre: cnt=%0d, want 3", cnt[2]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout[k] !== 10'h000 || strb[k] !== 1'b0 || rdy[k] !== 1'b1 || cnt[k] !== 3'd0) begin
                fails++;
                $display("FAIL rmid_async[%0d]: dout=%h strb=%b rdy=%b cnt=%0d, want 000 0 1 0",
                         k, dout[k], strb[k], rdy[k], cnt[k]);
            end
        end
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (strb[2] !== 1'b0 || cnt[2] !== 3'd0) begin
                fails++;
                $display("FAIL rmid_quiet: cycle %0d strb=%b cnt=%0d, want 0 0", c, strb[2], cnt[2]);
            end
        end
        in_valid = 1'b1;
        in_data = 9'h0FF;
        exp_q.push_back(10'h0FF);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (strb[2] !== 1'b1 || dout[2] !== e) begin
            fails++;
            $display("FAIL rmid_new: strb=%b dout=%h, want 1 %h", strb[2], dout[2], e);
        end
    endtask

`ifdef PARITY_INJECT_EN
    task automatic test_inject;
        reset_dut();
        @(negedge clk);
        err_inject = 1'b1;
        @(negedge clk);
        err_inject = 1'b0;
        in_valid = 1'b1;
        in_data = 9'h000;
        exp_q.push_back(10'h200);
        @(negedge clk);
        in_data = 9'h001;
        exp_q.push_back(10'h201);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (strb[0] !== 1'b1 || dout[0] !== e) begin
                fails++;
                $display("FAIL inject_%0d: strb=%b dout=%h, want 1 %h", c, strb[0], dout[0], e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_pacing();
        test_backpressure();
        test_reset_mid();
`ifdef PARITY_INJECT_EN
        test_inject();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
